// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decides per-stage stall/flush and PC redirect
// from load-use, branch, fetch/data memory waits and traps, and keeps two
// performance counters (stalled cycles, redirect events).
module hazard_ctrl #(
    parameter int unsigned TRAP_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdu_load_stall,
    input  logic        ex_branch_take,
    input  logic        if_mem_wait,
    input  logic        mem_mem_wait,
    input  logic        trap_req,
    input  logic        cnt_clear,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic [1:0]  pc_redirect_sel,
    output logic        ctrl_busy,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned DRAIN_W = 3;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(TRAP_FLUSH_CYCLES - 1);
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_TRAP = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_BR_WAIT    = 2'b01,
        ST_TRAP_DRAIN = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_nxt;
    logic [CNT_W-1:0]   r_perf_stall_cycles;
    logic [CNT_W-1:0]   r_perf_flush_events;

    // Stage vectors ordered {if, id, ex, mem}
    logic [3:0]         w_stall;
    logic [3:0]         w_flush;
    logic [1:0]         w_sel;
    logic               w_any_stall;
    logic               w_redirect;

    // State and drain counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Next-state and raw stall/flush/redirect decode
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_stall     = 4'b0000;
        w_flush     = 4'b0000;
        w_sel       = SEL_NONE;
        case (r_state)
            ST_RUN: begin
                if (mem_mem_wait) begin
                    w_stall = 4'b1111;
                end else if (trap_req) begin
                    w_flush = 4'b1111;
                    w_sel   = SEL_TRAP;
                    if (TRAP_FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_TRAP_DRAIN;
                        w_drain_nxt = DRAIN_LOAD;
                    end
                end else if (ex_branch_take) begin
                    w_flush = 4'b1100;
                    w_sel   = SEL_BR;
                    if (if_mem_wait) begin
                        w_state_nxt = ST_BR_WAIT;
                    end
                end else if (hdu_load_stall) begin
                    // Hold the load-dependent instruction, bubble into EX
                    w_stall = 4'b1000;
                    w_flush = 4'b0100;
                end
            end
            ST_BR_WAIT: begin
                if (mem_mem_wait) begin
                    w_stall = 4'b1111;
                    w_flush = 4'b1000;
                    if (!if_mem_wait) begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (trap_req) begin
                    // Trap wins over the pending wrong-path fetch
                    w_flush = 4'b1111;
                    w_sel   = SEL_TRAP;
                    if (TRAP_FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_TRAP_DRAIN;
                        w_drain_nxt = DRAIN_LOAD;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_flush = 4'b1000;
                    if (!if_mem_wait) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_TRAP_DRAIN: begin
                w_flush     = 4'b1110;
                w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
                if (r_drain_cnt <= DRAIN_W'(1)) begin
                    w_state_nxt = ST_RUN;
                    w_drain_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_drain_nxt = '0;
            end
        endcase
    end

    // Outputs forced quiet while reset is held
    assign if_stall        = w_stall[3] & ~rst;
    assign id_stall        = w_stall[2] & ~rst;
    assign ex_stall        = w_stall[1] & ~rst;
    assign mem_stall       = w_stall[0] & ~rst;
    assign if_flush        = w_flush[3] & ~rst;
    assign id_flush        = w_flush[2] & ~rst;
    assign ex_flush        = w_flush[1] & ~rst;
    assign mem_flush       = w_flush[0] & ~rst;
    assign pc_redirect_sel = rst ? SEL_NONE : w_sel;
    assign ctrl_busy       = (r_state != ST_RUN) & ~rst;

    assign w_any_stall = if_stall | id_stall | ex_stall | mem_stall;
    assign w_redirect  = (pc_redirect_sel != SEL_NONE);

    // Performance counters, wrap naturally, clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cycles <= '0;
            r_perf_flush_events <= '0;
        end else if (cnt_clear) begin
            r_perf_stall_cycles <= '0;
            r_perf_flush_events <= '0;
        end else begin
            if (w_any_stall) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + CNT_W'(1);
            end
            if (w_redirect) begin
                r_perf_flush_events <= r_perf_flush_events + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_flush_events = r_perf_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized run
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned TFC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        hdu_load_stall, ex_branch_take, if_mem_wait;
    logic        mem_mem_wait, trap_req, cnt_clear;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [1:0]  pc_redirect_sel;
    logic        ctrl_busy;
    logic [31:0] perf_stall_cycles, perf_flush_events;

    int n_checks = 0;
    int n_errors = 0;

    // {stalls if..mem, flushes if..mem, sel, busy}
    wire [10:0] obs = {if_stall, id_stall, ex_stall, mem_stall,
                       if_flush, id_flush, ex_flush, mem_flush,
                       pc_redirect_sel, ctrl_busy};

    hazard_ctrl #(.TRAP_FLUSH_CYCLES(TFC)) dut (
        .clk               (clk),
        .rst               (rst),
        .hdu_load_stall    (hdu_load_stall),
        .ex_branch_take    (ex_branch_take),
        .if_mem_wait       (if_mem_wait),
        .mem_mem_wait      (mem_mem_wait),
        .trap_req          (trap_req),
        .cnt_clear         (cnt_clear),
        .if_stall          (if_stall),
        .id_stall          (id_stall),
        .ex_stall          (ex_stall),
        .mem_stall         (mem_stall),
        .if_flush          (if_flush),
        .id_flush          (id_flush),
        .ex_flush          (ex_flush),
        .mem_flush         (mem_flush),
        .pc_redirect_sel   (pc_redirect_sel),
        .ctrl_busy         (ctrl_busy),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
    );

    always #5 clk = ~clk;

    // v = {hdu, branch, if_wait, mem_wait, trap, clear}
    task automatic set_in(input logic [5:0] v);
        {hdu_load_stall, ex_branch_take, if_mem_wait, mem_mem_wait, trap_req, cnt_clear} = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(6'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(6'b111111);
        #1;
        n_checks++;
        if (obs !== 11'b0) begin n_errors++; $display("FAIL reset.out got=%b exp=%b", obs, 11'b0); end
        @(posedge clk); #1;
        n_checks++;
        if (perf_stall_cycles !== 32'd0 || perf_flush_events !== 32'd0) begin
            n_errors++; $display("FAIL reset.cnt got=%0d/%0d exp=0/0", perf_stall_cycles, perf_flush_events);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); set_in(6'b100000); #1;
        n_checks++;
        if (obs !== {4'b1000, 4'b0100, 2'b00, 1'b0}) begin n_errors++; $display("FAIL load_use.out got=%b exp=%b", obs, {4'b1000, 4'b0100, 3'b000}); end
        @(negedge clk); set_in(6'b0); #1;
        n_checks++;
        if (obs !== 11'b0 || perf_stall_cycles !== 32'd1 || perf_flush_events !== 32'd0) begin
            n_errors++; $display("FAIL load_use.after got=%b %0d %0d exp=0 1 0", obs, perf_stall_cycles, perf_flush_events);
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        @(negedge clk); set_in(6'b011000); #1;
        n_checks++;
        if (obs !== {4'b0000, 4'b1100, 2'b01, 1'b0}) begin n_errors++; $display("FAIL branch.c0 got=%b exp=%b", obs, {4'b0000, 4'b1100, 3'b010}); end
        @(negedge clk); set_in(6'b001000); #1;
        n_checks++;
        if (obs !== {4'b0000, 4'b1000, 2'b00, 1'b1}) begin n_errors++; $display("FAIL branch.c1 got=%b exp=%b", obs, {4'b0000, 4'b1000, 3'b001}); end
        @(negedge clk); set_in(6'b110000); #1;
        n_checks++;
        if (obs !== {4'b0000, 4'b1000, 2'b00, 1'b1}) begin n_errors++; $display("FAIL branch.c2 got=%b exp=%b", obs, {4'b0000, 4'b1000, 3'b001}); end
        @(negedge clk); set_in(6'b0); #1;
        n_checks++;
        if (obs !== 11'b0 || perf_flush_events !== 32'd1 || perf_stall_cycles !== 32'd0) begin
            n_errors++; $display("FAIL branch.c3 got=%b %0d %0d exp=0 1 0", obs, perf_flush_events, perf_stall_cycles);
        end
    endtask

    task automatic test_trap_drain();
        do_reset();
        @(negedge clk); set_in(6'b000010); #1;
        n_checks++;
        if (obs !== {4'b0000, 4'b1111, 2'b10, 1'b0}) begin n_errors++; $display("FAIL trap.c0 got=%b exp=%b", obs, {4'b0000, 4'b1111, 3'b100}); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); set_in((c == 1) ? 6'b110110 : 6'b0); #1;
            n_checks++;
            if (obs !== {4'b0000, 4'b1110, 2'b00, 1'b1}) begin n_errors++; $display("FAIL trap.c%0d got=%b exp=%b", c, obs, {4'b0000, 4'b1110, 3'b001}); end
        end
        @(negedge clk); set_in(6'b0); #1;
        n_checks++;
        if (obs !== 11'b0 || perf_flush_events !== 32'd1) begin n_errors++; $display("FAIL trap.c3 got=%b %0d exp=0 1", obs, perf_flush_events); end
    endtask

    task automatic test_priority();
        do_reset();
        @(negedge clk); set_in(6'b111110); #1;
        n_checks++;
        if (obs !== {4'b1111, 4'b0000, 3'b000}) begin n_errors++; $display("FAIL prio.out got=%b exp=%b", obs, {4'b1111, 7'b0}); end
        @(negedge clk); set_in(6'b0); #1;
        n_checks++;
        if (obs !== 11'b0 || perf_stall_cycles !== 32'd1 || perf_flush_events !== 32'd0) begin
            n_errors++; $display("FAIL prio.after got=%b %0d %0d exp=0 1 0", obs, perf_stall_cycles, perf_flush_events);
        end
    endtask

    task automatic test_trap_in_br_wait();
        do_reset();
        @(negedge clk); set_in(6'b011000);
        @(negedge clk); set_in(6'b001010); #1;
        n_checks++;
        if (obs !== {4'b0000, 4'b1111, 2'b10, 1'b1}) begin n_errors++; $display("FAIL brtrap.c1 got=%b exp=%b", obs, {4'b0000, 4'b1111, 3'b101}); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); set_in(6'b001000); #1;
            n_checks++;
            if (obs !== {4'b0000, 4'b1110, 2'b00, 1'b1}) begin n_errors++; $display("FAIL brtrap.c%0d got=%b exp=%b", c, obs, {4'b0000, 4'b1110, 3'b001}); end
        end
        @(negedge clk); set_in(6'b001000); #1;
        n_checks++;
        if (obs !== 11'b0 || perf_flush_events !== 32'd2) begin n_errors++; $display("FAIL brtrap.c4 got=%b %0d exp=0 2", obs, perf_flush_events); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        @(negedge clk);
        force dut.r_perf_stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_stall_cycles;
        set_in(6'b000100); #1;
        n_checks++;
        if (perf_stall_cycles !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap.preload got=%h exp=ffffffff", perf_stall_cycles); end
        @(negedge clk); set_in(6'b000100); #1;
        n_checks++;
        if (perf_stall_cycles !== 32'd0) begin n_errors++; $display("FAIL wrap.zero got=%h exp=0", perf_stall_cycles); end
        @(negedge clk); set_in(6'b000101); #1;
        n_checks++;
        if (perf_stall_cycles !== 32'd1) begin n_errors++; $display("FAIL wrap.count got=%h exp=1", perf_stall_cycles); end
        @(negedge clk); set_in(6'b0); #1;
        n_checks++;
        if (perf_stall_cycles !== 32'd0) begin n_errors++; $display("FAIL clear.prio got=%h exp=0", perf_stall_cycles); end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk); set_in(6'b000010);
        @(negedge clk); set_in(6'b100000);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 11'b0 || perf_flush_events !== 32'd0) begin
            n_errors++; $display("FAIL async.during got=%b %0d exp=0 0", obs, perf_flush_events);
        end
        @(negedge clk); rst = 1'b0; set_in(6'b0); #1;
        n_checks++;
        if (obs !== 11'b0) begin n_errors++; $display("FAIL async.after got=%b exp=0", obs); end
        @(negedge clk); set_in(6'b100000); #1;
        n_checks++;
        if (obs !== {4'b1000, 4'b0100, 3'b000}) begin n_errors++; $display("FAIL async.run got=%b exp=%b", obs, {4'b1000, 4'b0100, 3'b000}); end
    endtask

    // Model: drain_left = remaining pure-drain cycles, br_pend = refetch pending
    task automatic test_random();
        int          drain_left;
        bit          br_pend;
        int          n_drain;
        bit          n_br;
        logic [31:0] m_stall, m_flush;
        logic [3:0]  st, fl;
        logic [1:0]  sel;
        logic [10:0] exp_obs;
        logic        prev_trap;
        do_reset();
        drain_left = 0; br_pend = 0; m_stall = 0; m_flush = 0; prev_trap = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            hdu_load_stall = ($urandom_range(0, 1) == 1);
            ex_branch_take = ($urandom_range(0, 3) == 0);
            if_mem_wait    = ($urandom_range(0, 1) == 1);
            mem_mem_wait   = ($urandom_range(0, 4) == 0);
            trap_req       = !prev_trap && ($urandom_range(0, 11) == 0);
            cnt_clear      = ($urandom_range(0, 40) == 0);
            prev_trap      = trap_req;
            #1;
            st = 4'b0; fl = 4'b0; sel = 2'b00;
            n_drain = drain_left; n_br = br_pend;
            if (drain_left > 0) begin
                fl = 4'b1110; n_drain = drain_left - 1;
            end else if (mem_mem_wait) begin
                st = 4'b1111;
                if (br_pend) begin fl = 4'b1000; n_br = if_mem_wait; end
            end else if (trap_req) begin
                fl = 4'b1111; sel = 2'b10; n_br = 0; n_drain = int'(TFC) - 1;
            end else if (br_pend) begin
                fl = 4'b1000; n_br = if_mem_wait;
            end else if (ex_branch_take) begin
                fl = 4'b1100; sel = 2'b01; n_br = if_mem_wait;
            end else if (hdu_load_stall) begin
                st = 4'b1000; fl = 4'b0100;
            end
            exp_obs = {st, fl, sel, (drain_left > 0) || br_pend};
            n_checks++;
            if (obs !== exp_obs || perf_stall_cycles !== m_stall || perf_flush_events !== m_flush) begin
                n_errors++;
                $display("FAIL random.c%0d got=%b %0d %0d exp=%b %0d %0d", n, obs,
                         perf_stall_cycles, perf_flush_events, exp_obs, m_stall, m_flush);
            end
            drain_left = n_drain; br_pend = n_br;
            if (cnt_clear) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (st != 4'b0) m_stall = m_stall + 1;
                if (sel != 2'b00) m_flush = m_flush + 1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(6'b0);
        test_reset();
        test_load_use();
        test_branch_wait();
        test_trap_drain();
        test_priority();
        test_trap_in_br_wait();
        test_counter_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
